mem_readback_scanner: RTL and testbench

//  Downstream consumer of the simple dual-port init memory's read port. On start, sweeps raddr over an

---
 rtl/mem_readback_pkg.sv | 25 ++
 rtl/readback_beat_fifo.sv | 51 +++++
 rtl/mem_readback_scanner.sv | 154 +++++++++++++++
 tb/tb_mem_readback_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readback_pkg.sv
// Shared types for the memory readback scanner: beat layout, FSM states, checksum width.
package mem_readback_pkg;

  localparam int ADDR_W_PKG  = 12;
  localparam int WID_MEM_PKG = 18;
  localparam int CHECKSUM_W  = 32;

  typedef logic [ADDR_W_PKG-1:0]  addr_t;
  typedef logic [WID_MEM_PKG-1:0] word_t;

  typedef struct packed {
    addr_t addr;
    word_t data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/readback_beat_fifo.sv
// Show-ahead synchronous FIFO holding {addr, data} beats; rdata is the head entry whenever !empty.
module readback_beat_fifo
  import mem_readback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BEAT_W-1:0] wdata,
  input  logic              pop,
  output logic [BEAT_W-1:0] rdata,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= beat_t'(wdata);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_readback_scanner.sv
// Sweeps a memory read port over an inclusive address range and streams {addr, data} beats.
// Optional running checksum of accepted beats when READBACK_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing reads while output credits allow
// DRAIN | last address issued, emptying pipeline and FIFO
// DONE  | one-cycle done pulse
module mem_readback_scanner
  import mem_readback_pkg::*;
#(
  parameter int WID_MEM    = WID_MEM_PKG,
  parameter int DEPTH_MEM  = 4096,
  parameter int ADDR_W     = ADDR_W_PKG,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     raddr,
  input  logic [WID_MEM-1:0]    mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [WID_MEM-1:0]    m_data,
  output logic [CHECKSUM_W-1:0] checksum
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] last_eff;
  logic              issue;
  logic              issue_last;
  logic              credit_ok;
  logic              drain_done;

  // Two-stage read pipeline: stage 1 is the edge raddr is presented, stage 2 has mem_dout valid.
  logic              v1;
  logic              v2;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [1:0]        inflight;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [BEAT_W-1:0] fifo_wdata;
  logic [BEAT_W-1:0] fifo_rdata;
  beat_t             head;

  function automatic logic [ADDR_W-1:0] addr_incr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH_MEM - 1)) ? '0 : a + 1'b1;
  endfunction

  assign inflight   = {1'b0, v1} + {1'b0, v2};
  // Credits count FIFO occupancy before any same-edge pop, so no beat is ever issued without room.
  assign credit_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign issue_addr = (state == IDLE) ? first_addr : cur_addr;
  assign last_eff   = (state == IDLE) ? last_addr : last_q;
  assign issue_last = (issue_addr == last_eff);
  assign issue      = ((state == IDLE) && start) || ((state == SCAN) && credit_ok);

  assign drain_done = !v1 && !v2 &&
                      (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = issue_last ? DRAIN : SCAN;
      SCAN:    if (credit_ok && issue_last) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      raddr    <= '0;
      cur_addr <= '0;
      last_q   <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      a1       <= '0;
      a2       <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) last_q <= last_addr;
      if (issue) begin
        raddr    <= issue_addr;
        cur_addr <= addr_incr(issue_addr);
      end
      v1 <= issue;
      a1 <= issue_addr;
      v2 <= v1;
      a2 <= a1;
    end
  end

  assign fifo_push  = v2;
  assign fifo_wdata = {a2, mem_dout};
  assign fifo_pop   = m_valid && m_ready;

  readback_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head    = beat_t'(fifo_rdata);
  assign m_valid = !fifo_empty;
  assign m_addr  = head.addr;
  assign m_data  = head.data;
  assign busy    = (state == SCAN) || (state == DRAIN);
  assign done    = (state == DONE);

`ifdef READBACK_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if ((state == IDLE) && start) begin
      sum_q <= '0;
    end else if (fifo_pop) begin
      sum_q <= sum_q + CHECKSUM_W'(m_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_readback_scanner.sv
// Scoreboard bench for mem_readback_scanner: stimulus queues expected beats, a monitor pops and compares.
module tb_mem_readback_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] first_addr = '0;
  logic [11:0] last_addr = '0;
  logic        busy;
  logic        done;
  logic [11:0] raddr;
  logic [17:0] mem_dout = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [11:0] m_addr;
  logic [17:0] m_data;
  logic [31:0] checksum;

  int          vectors = 0;
  int          errs = 0;
  int          cyc = 0;
  int          beats = 0;
  int          last_hs_cyc = -10;
  logic [11:0] last_acc = '0;
  logic        all_ones = 1'b0;
  logic [29:0] q [$];
  logic        prev_stall = 1'b0;
  logic [29:0] prev_beat = '0;

  mem_readback_scanner dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .mem_dout   (mem_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_dout <= all_ones ? 18'h3FFFF : ({6'd0, raddr} ^ 18'h2AA00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_beat", {2'b00, m_addr, m_data}, {2'b00, prev_beat});
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_beat actual addr=%h data=%h required=no beat", m_addr, m_data);
        end else begin
          check("beat", {2'b00, m_addr, m_data}, {2'b00, q.pop_front()});
        end
        beats++;
        last_acc = m_addr;
        last_hs_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_beat = {m_addr, m_data};
    end
  end

  // Queue expected beats, then drive a one-cycle start; returns #1 after the sampling edge.
  task automatic run_scan(input logic [11:0] f, input logic [11:0] l);
    logic [11:0] a;
    a = f;
    forever begin
      q.push_back({a, all_ones ? 18'h3FFFF : ({6'd0, a} ^ 18'h2AA00)});
      if (a == l) break;
      a = a + 12'd1;
    end
    @(posedge clk); #1;
    start = 1'b1; first_addr = f; last_addr = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= bound) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_done_lat"}, cyc, last_hs_cyc + 1);
      check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({name, "_all_beats"}, q.size(), 32'd0);
    end
  endtask

  initial begin
    int n;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_raddr", {20'd0, raddr}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: short scan, latency and back-to-back beats
    run_scan(12'd0, 12'd3);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_first_valid_lat", n, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1", 50);
    check("t1_beats", beats, 32'd4);
`ifndef READBACK_CHECKSUM_EN
    check("t1_checksum_off", checksum, 32'd0);
`endif

    // 2: backpressure mid-scan
    n = beats;
    run_scan(12'd0, 12'd63);
    begin
      int k;
      k = 0;
      while (beats - n < 5 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    @(posedge clk); #1 m_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t2_issued_beyond", {20'd0, raddr - last_acc}, 32'd4);
    m_ready = 1'b1;
    wait_done("t2", 300);
    check("t2_beats", beats - n, 32'd64);

    // 3: wrap-around range
    run_scan(12'd4094, 12'd1);
    wait_done("t3", 50);

    // 4: single beat, start while busy ignored
    n = beats;
    run_scan(12'd7, 12'd7);
    check("t4_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; first_addr = 12'd100; last_addr = 12'd101;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4", 50);
    repeat (6) @(posedge clk);
    #1;
    check("t4_beats", beats - n, 32'd1);
    check("t4_idle_after", {31'd0, busy}, 32'd0);

    // 5: async reset mid-scan
    n = beats;
    run_scan(12'd0, 12'd63);
    begin
      int k;
      k = 0;
      while (beats - n < 20 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_raddr", {20'd0, raddr}, 32'd0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    n = beats;
    run_scan(12'd0, 12'd3);
    wait_done("t5", 50);
    check("t5_beats", beats - n, 32'd4);

    // 6: full-range scan of all-ones memory
    all_ones = 1'b1;
    repeat (2) @(posedge clk);
    n = beats;
    run_scan(12'd0, 12'd4095);
    wait_done("t6", 6000);
    check("t6_beats", beats - n, 32'd4096);
`ifdef READBACK_CHECKSUM_EN
    check("t6_checksum", checksum, 32'h3FFFF000);
    repeat (3) @(posedge clk);
    #1 check("t6_checksum_hold", checksum, 32'h3FFFF000);
`else
    check("t6_checksum_off", checksum, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
